// File: rtl/seven_seg_pkg.sv
// Shared constants for the two-digit seven-segment display interface.
// Segment vectors are ordered gfedcba: bit 0 = a, bit 1 = b, ... bit 6 = g,
// and are always normalized (1 = segment lit) before being compared against
// these glyphs. The encoder and the receiver decode both use this table, so
// the two directions cannot drift apart.
package seven_seg_pkg;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Receiver phase FSM encoding.
  localparam logic [1:0] ST_WAIT_EDGE = 2'd0;
  localparam logic [1:0] ST_SETTLE    = 2'd1;
  localparam logic [1:0] ST_HOLD      = 2'd2;

  function automatic logic [SEG_W-1:0] glyph_of(input logic [3:0] nib);
    logic [SEG_W-1:0] g;
    case (nib)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seven_seg_to_nibble.sv
// Combinational glyph decoder: normalized gfedcba pattern to hex nibble.
// Ports:
//   seg    in  7  normalized segment pattern
//   hit    out 1  pattern matches one of the 16 hex glyphs
//   nibble out 4  decoded value (0 when no hit)
module seven_seg_to_nibble
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic             hit,
  output logic [3:0]       nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (seg == glyph_of(4'(i))) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_rx.sv
// Receiver for a multiplexed two-digit seven-segment bus. Samples seg/ca,
// waits for each digit's pattern to settle, decodes it and reassembles the
// displayed byte.
// Ports:
//   clk     in  1  clock, rising edge
//   rst_n   in  1  asynchronous active-low reset
//   seg_in  in  7  segment lines, bit 0 = a .. bit 6 = g (asynchronous)
//   ca_in   in  1  digit select, 0 = low nibble, 1 = high nibble (asynchronous)
//   value   out 8  last complete byte {digit1, digit0}
//   valid   out 1  one-cycle pulse, value updated this cycle
//   err     out 1  one-cycle pulse, a stable pattern matched no glyph
module seven_seg_rx
  import seven_seg_pkg::*;
#(
  parameter int unsigned STABLE_CNT     = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEG_W-1:0] seg_in,
  input  logic             ca_in,
  output logic [7:0]       value,
  output logic             valid,
  output logic             err
);

  localparam logic [7:0] CntMax = 8'(STABLE_CNT);

  logic [SEG_W:0]   sync1_q, sync2_q;
  logic             ca_s, ca_prev_q, ca_edge;
  logic [SEG_W-1:0] seg_s, seg_prev_q;
  logic             seg_chg;
  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             latch, abandon0;
  logic             dec_hit;
  logic [3:0]       dec_nib;
  logic [3:0]       d0_q, d0_d, d1_q, d1_d;
  logic             have_d0_q, have_d0_d;
  logic             pend_valid_q, pend_valid_d, pend_err_q, pend_err_d;
  logic [7:0]       value_q;
  logic             valid_q, err_q;

  assign ca_s    = sync2_q[SEG_W];
  assign seg_s   = SEG_ACTIVE_LOW ? ~sync2_q[SEG_W-1:0] : sync2_q[SEG_W-1:0];
  assign ca_edge = ca_s ^ ca_prev_q;
  assign seg_chg = seg_s != seg_prev_q;

  seven_seg_to_nibble u_dec (
    .seg    (seg_s),
    .hit    (dec_hit),
    .nibble (dec_nib)
  );

  // Phase FSM. A ca edge always restarts the count, even if seg moved too.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch    = 1'b0;
    abandon0 = 1'b0;
    case (state_q)
      ST_WAIT_EDGE: begin
        if (ca_edge) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      ST_SETTLE: begin
        if (ca_edge) begin
          cnt_d    = 8'd1;
          abandon0 = ~ca_prev_q;
        end else if (seg_chg) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d = (cnt_q >= CntMax) ? CntMax : cnt_q + 8'd1;
          if (cnt_d == CntMax) begin
            latch   = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (ca_edge) begin
          state_d = ST_SETTLE;
          cnt_d   = 8'd1;
        end
      end
      default: state_d = ST_WAIT_EDGE;
    endcase
  end

  // Digit registers and frame tracking. Blank or unknown patterns count as
  // an abandoned phase, which breaks a frame only when it is digit 0.
  always_comb begin
    d0_d         = d0_q;
    d1_d         = d1_q;
    have_d0_d    = have_d0_q;
    pend_valid_d = 1'b0;
    pend_err_d   = 1'b0;
    if (abandon0) have_d0_d = 1'b0;
    if (latch) begin
      if (dec_hit) begin
        if (!ca_s) begin
          d0_d      = dec_nib;
          have_d0_d = 1'b1;
        end else begin
          d1_d         = dec_nib;
          pend_valid_d = have_d0_q;
          have_d0_d    = 1'b0;
        end
      end else begin
        pend_err_d = seg_s != SEG_BLANK;
        if (!ca_s) have_d0_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      ca_prev_q    <= 1'b0;
      seg_prev_q   <= '0;
      state_q      <= ST_WAIT_EDGE;
      cnt_q        <= 8'd0;
      d0_q         <= 4'h0;
      d1_q         <= 4'h0;
      have_d0_q    <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_err_q   <= 1'b0;
      value_q      <= 8'h00;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sync1_q      <= {ca_in, seg_in};
      sync2_q      <= sync1_q;
      ca_prev_q    <= ca_s;
      seg_prev_q   <= seg_s;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      d0_q         <= d0_d;
      d1_q         <= d1_d;
      have_d0_q    <= have_d0_d;
      pend_valid_q <= pend_valid_d;
      pend_err_q   <= pend_err_d;
      // Outputs trail the latch by one cycle.
      valid_q      <= pend_valid_q;
      err_q        <= pend_err_q;
      if (pend_valid_q) value_q <= {d1_q, d0_q};
    end
  end

  assign value = value_q;
  assign valid = valid_q;
  assign err   = err_q;

endmodule

// File: tb/tb_seven_seg_rx.sv
module tb_seven_seg_rx;

  localparam int unsigned Stable = 4;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg;
  logic [6:0] seg_al;
  logic       ca;
  logic [7:0] value, value_al;
  logic       valid, valid_al;
  logic       err, err_al;

  int checks = 0;
  int failures = 0;
  int n_valid = 0, n_err = 0, n_valid_al = 0, n_err_al = 0;
  int v0, e0;

  seven_seg_rx #(
    .STABLE_CNT     (Stable),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg_in (seg),
    .ca_in  (ca),
    .value  (value),
    .valid  (valid),
    .err    (err)
  );

  seven_seg_rx #(
    .STABLE_CNT     (Stable),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut_al (
    .clk    (clk),
    .rst_n  (rst_n),
    .seg_in (seg_al),
    .ca_in  (ca),
    .value  (value_al),
    .valid  (valid_al),
    .err    (err_al)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid)    n_valid    <= n_valid + 1;
    if (err)      n_err      <= n_err + 1;
    if (valid_al) n_valid_al <= n_valid_al + 1;
    if (err_al)   n_err_al   <= n_err_al + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one display phase and hold it for n cycles (from a negedge).
  task automatic hold(input logic c, input logic [6:0] s, input int n);
    ca  = c;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ca    = 1'b1;
    seg   = 7'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    ca     = 1'b1;
    seg    = 7'h00;
    seg_al = 7'h7F;  // inverted blank
    repeat (3) @(negedge clk);
    check("reset_value", value, 8'h00);
    check("reset_valid", valid, 1'b0);
    check("reset_err", err, 1'b0);
    rst_n = 1'b1;

    // Stable frame 3/b; valid lands Stable+3 edges after the digit1 phase starts.
    hold(1'b1, 7'h00, 5);
    hold(1'b0, 7'h4F, 20);
    hold(1'b1, 7'h7C, Stable + 2);
    check("frame_valid_early", valid, 1'b0);
    @(negedge clk);
    check("frame_valid_on_time", valid, 1'b1);
    check("frame_value", value, 8'hB3);
    hold(1'b1, 7'h7C, 13);
    check("frame_valid_count", n_valid, 1);
    check("frame_err_count", n_err, 0);

    // Ghosting: digit0 held one cycle short of the stability count.
    do_reset();
    v0 = n_valid;
    e0 = n_err;
    hold(1'b1, 7'h00, 5);
    hold(1'b0, 7'h06, Stable - 1);
    hold(1'b1, 7'h3F, 20);
    check("ghost_no_valid", n_valid - v0, 0);
    check("ghost_value", value, 8'h00);
    check("ghost_no_err", n_err - e0, 0);

    // Bad glyph on digit0, then a clean 5/A frame.
    v0 = n_valid;
    e0 = n_err;
    hold(1'b0, 7'h01, 20);
    hold(1'b1, 7'h06, 20);
    check("bad_err_once", n_err - e0, 1);
    check("bad_no_valid", n_valid - v0, 0);
    hold(1'b0, 7'h6D, 20);
    hold(1'b1, 7'h77, 20);
    check("clean_valid", n_valid - v0, 1);
    check("clean_value", value, 8'hA5);

    // Settling: final 6D held exactly Stable cycles before ca flips.
    v0 = n_valid;
    hold(1'b0, 7'h66, 2);
    hold(1'b0, 7'h6D, 2);
    hold(1'b0, 7'h66, 2);
    hold(1'b0, 7'h6D, Stable);
    hold(1'b1, 7'h7D, 20);
    check("settle_valid", n_valid - v0, 1);
    check("settle_value", value, 8'h65);

    // Reset after digit0 latched.
    hold(1'b0, 7'h4F, 20);
    rst_n = 1'b0;
    #1;
    check("midrst_value", value, 8'h00);
    check("midrst_valid", valid, 1'b0);
    check("midrst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid;
    hold(1'b1, 7'h79, 20);
    check("midrst_d1_only", n_valid - v0, 0);
    hold(1'b0, 7'h07, 20);
    hold(1'b1, 7'h79, 20);
    check("midrst_frame_valid", n_valid - v0, 1);
    check("midrst_frame_value", value, 8'hE7);

    // Active-low instance: inverted 8 (7F) and F (71).
    seg_al = 7'h00;
    hold(1'b0, 7'h00, 20);
    seg_al = 7'h0E;
    hold(1'b1, 7'h00, 20);
    check("al_value", value_al, 8'hF8);
    check("al_valid_count", n_valid_al, 1);
    check("al_err_count", n_err_al, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
